pe_array_controller: RTL and testbench

// Sequences the 16x16 output-stationary MAC array for one layer job. Counts reduction beats per output tile,

---
 rtl/pe_ctrl_pkg.sv | 19 +
 rtl/pe_array_controller.sv | 135 +++++++++++++
 tb/tb_pe_array_controller.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared types and default sizing for the PE array controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pe_ctrl_pkg;

  localparam int DEF_K_CNT_WIDTH = 16;
  localparam int DEF_T_CNT_WIDTH = 16;
  // Must track the register depth of the mac unit inside each PE.
  localparam int DEF_MAC_LATENCY = 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    DRAIN  = 3'd2,
    OUTPUT = 3'd3,
    FINISH = 3'd4
  } pe_state_t;

endpackage

// File: rtl/pe_array_controller.sv
// Sequences the 16x16 output-stationary MAC array through one layer job: k beats per tile, drain, writeback.
// Latency: start -> first beat 1 cycle; last beat -> out_valid MAC_LATENCY+1 cycles; handshake -> done 1 cycle.
// Backpressure: op_valid low stalls accumulation; out_ready low holds the tile and blocks all operand beats.
//
// Ports:
//   clk, rst_in                    clock and synchronous active-high reset
//   start, cfg_k_steps, cfg_n_tiles job launch; cfg latched when start is taken in IDLE
//   busy, done                     job in flight / one-cycle completion pulse
//   op_valid, op_ready             operand fetch handshake (one beat = activations+weights)
//   pe_input_valid                 beat strobe to the array (op_valid && op_ready)
//   pe_accumulate_internal         0 = load first product of tile, 1 = accumulate
//   out_valid, out_ready           finished tile handshake with writeback
//   out_tile_idx                   0-based index of the tile on out_valid
module pe_array_controller
  import pe_ctrl_pkg::*;
#(
  parameter int K_CNT_WIDTH = DEF_K_CNT_WIDTH,
  parameter int T_CNT_WIDTH = DEF_T_CNT_WIDTH,
  parameter int MAC_LATENCY = DEF_MAC_LATENCY
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   start,
  input  logic [K_CNT_WIDTH-1:0] cfg_k_steps,
  input  logic [T_CNT_WIDTH-1:0] cfg_n_tiles,
  output logic                   busy,
  output logic                   done,
  input  logic                   op_valid,
  output logic                   op_ready,
  output logic                   pe_input_valid,
  output logic                   pe_accumulate_internal,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [T_CNT_WIDTH-1:0] out_tile_idx
);

  localparam int DW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;
  localparam logic [DW-1:0]          DRAIN_LAST = DW'(MAC_LATENCY - 1);
  localparam logic [K_CNT_WIDTH-1:0] K_ONE      = K_CNT_WIDTH'(1);
  localparam logic [T_CNT_WIDTH-1:0] T_ONE      = T_CNT_WIDTH'(1);
  localparam logic [DW-1:0]          D_ONE      = DW'(1);

  pe_state_t              state, state_n;
  logic [K_CNT_WIDTH-1:0] k_cnt, k_cnt_n;
  logic [T_CNT_WIDTH-1:0] tile_cnt, tile_cnt_n;
  logic [DW-1:0]          drain_cnt, drain_cnt_n;
  logic [K_CNT_WIDTH-1:0] k_steps, k_steps_n;
  logic [T_CNT_WIDTH-1:0] n_tiles, n_tiles_n;

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state     <= IDLE;
      k_cnt     <= '0;
      tile_cnt  <= '0;
      drain_cnt <= '0;
      k_steps   <= '0;
      n_tiles   <= '0;
    end else begin
      state     <= state_n;
      k_cnt     <= k_cnt_n;
      tile_cnt  <= tile_cnt_n;
      drain_cnt <= drain_cnt_n;
      k_steps   <= k_steps_n;
      n_tiles   <= n_tiles_n;
    end
  end

  always_comb begin
    state_n     = state;
    k_cnt_n     = k_cnt;
    tile_cnt_n  = tile_cnt;
    drain_cnt_n = drain_cnt;
    k_steps_n   = k_steps;
    n_tiles_n   = n_tiles;
    unique case (state)
      IDLE: begin
        if (start) begin
          k_steps_n  = cfg_k_steps;
          n_tiles_n  = cfg_n_tiles;
          k_cnt_n    = '0;
          tile_cnt_n = '0;
          // An empty job still reports completion, without touching the array.
          state_n    = (cfg_k_steps == '0 || cfg_n_tiles == '0) ? FINISH : ACCUM;
        end
      end
      ACCUM: begin
        if (op_valid) begin
          // Compare against k_steps-1 before incrementing so a full-range count never wraps.
          if (k_cnt == k_steps - K_ONE) begin
            k_cnt_n     = '0;
            drain_cnt_n = '0;
            state_n     = DRAIN;
          end else begin
            k_cnt_n = k_cnt + K_ONE;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_n = OUTPUT;
        end else begin
          drain_cnt_n = drain_cnt + D_ONE;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          if (tile_cnt == n_tiles - T_ONE) begin
            state_n = FINISH;
          end else begin
            tile_cnt_n = tile_cnt + T_ONE;
            state_n    = ACCUM;
          end
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy         = (state != IDLE);
  assign done         = (state == FINISH);
  assign op_ready     = (state == ACCUM);
  assign out_valid    = (state == OUTPUT);
  assign out_tile_idx = tile_cnt;

  // Reset is synchronous, so the state is still ACCUM in the reset cycle; mask the
  // strobe so the array never sees a beat that the controller is about to forget.
  assign pe_input_valid         = op_valid && op_ready && !rst_in;
  assign pe_accumulate_internal = pe_input_valid && (k_cnt != '0);

endmodule

// File: tb/tb_pe_array_controller.sv
module tb_pe_array_controller;

  localparam int KW    = 16;
  localparam int TW    = 16;
  localparam int LAT   = 1;
  localparam int LANES = 16;

  logic          clk = 1'b0;
  logic          rst_in;
  logic          start;
  logic [KW-1:0] cfg_k_steps;
  logic [TW-1:0] cfg_n_tiles;
  logic          busy, done;
  logic          op_valid, op_ready;
  logic          pe_input_valid, pe_accumulate_internal;
  logic          out_valid, out_ready;
  logic [TW-1:0] out_tile_idx;

  pe_array_controller #(
    .K_CNT_WIDTH(KW),
    .T_CNT_WIDTH(TW),
    .MAC_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_in(rst_in),
    .start(start),
    .cfg_k_steps(cfg_k_steps),
    .cfg_n_tiles(cfg_n_tiles),
    .busy(busy),
    .done(done),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .pe_input_valid(pe_input_valid),
    .pe_accumulate_internal(pe_accumulate_internal),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_tile_idx(out_tile_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Operand stream (what fetch would deliver) and expected finished tiles.
  typedef struct {
    int unsigned idx;
    int unsigned hash;
    int unsigned k;
  } exp_t;

  logic [LANES*8-1:0] a_q[$];
  logic [LANES*8-1:0] w_q[$];
  exp_t               exp_q[$];
  logic [LANES*8-1:0] a_cur, w_cur;

  // Behavioural 16x16 output-stationary array driven by the controller's strobes.
  int unsigned arr[LANES][LANES];

  int  p_valid   = 100;
  int  bp_cycles = 0;
  bit  mon_off   = 1'b1;
  int  beats_in_tile = 0;
  int  job_beats = 0;
  int  done_cnt  = 0;
  int  first_beat_cyc = -1;
  int  outv_cyc  = -1;
  int  done_cyc  = -1;
  int  start_cyc = 0;
  bit  prev_ov = 1'b0, prev_or = 1'b0;
  logic [TW-1:0] prev_idx = '0;

  // Stimulus side: operand valid and writeback ready.
  int wcnt = 0;
  always @(posedge clk) begin
    #1;
    if (a_q.size() > 0 && $urandom_range(99) < p_valid) begin
      op_valid = 1'b1;
      a_cur    = a_q[0];
      w_cur    = w_q[0];
    end else begin
      op_valid = 1'b0;
    end
    if (out_valid) begin
      if (wcnt >= bp_cycles) out_ready = 1'b1;
      else begin
        out_ready = 1'b0;
        wcnt++;
      end
    end else begin
      out_ready = (bp_cycles == 0);
      wcnt = 0;
    end
  end

  // Monitor: samples on the falling edge, compares against the scoreboard.
  always @(negedge clk) begin
    if (mon_off) begin
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      if (!pe_input_valid) check("acc_gated", pe_accumulate_internal, 0);
      if (pe_input_valid) begin
        check("beat_while_out_valid", out_valid, 0);
        check("acc_internal_bit", pe_accumulate_internal, (beats_in_tile != 0));
        check("beat_has_stimulus", (a_q.size() > 0), 1);
        for (int i = 0; i < LANES; i++) begin
          for (int j = 0; j < LANES; j++) begin
            int unsigned ai, wj;
            ai = a_cur[i*8 +: 8];
            wj = w_cur[j*8 +: 8];
            if (pe_accumulate_internal) arr[i][j] = arr[i][j] + ai * wj;
            else arr[i][j] = ai * wj;
          end
        end
        if (a_q.size() > 0) begin
          void'(a_q.pop_front());
          void'(w_q.pop_front());
        end
        beats_in_tile++;
        job_beats++;
        if (first_beat_cyc < 0) first_beat_cyc = cyc;
      end
      if (out_valid && outv_cyc < 0) outv_cyc = cyc;
      if (prev_ov && !prev_or) begin
        check("out_valid_held", out_valid, 1);
        check("out_idx_held", out_tile_idx, prev_idx);
      end
      if (out_valid) check("op_ready_low_in_output", op_ready, 0);
      if (out_valid && out_ready) begin
        check("tile_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          int unsigned h;
          e = exp_q.pop_front();
          h = 0;
          for (int i = 0; i < LANES; i++)
            for (int j = 0; j < LANES; j++)
              h = h + (i * LANES + j + 1) * arr[i][j];
          check("tile_idx", out_tile_idx, e.idx);
          check("tile_beats", beats_in_tile, e.k);
          check("tile_result_hash", h, e.hash);
        end
        beats_in_tile = 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_ov  = out_valid;
      prev_or  = out_ready;
      prev_idx = out_tile_idx;
    end
  end

  // Build operand beats and the reference result of each tile (plain dot products).
  task automatic gen_job(input int k, input int n);
    for (int t = 0; t < n && k > 0; t++) begin
      int unsigned rf[LANES][LANES];
      exp_t e;
      for (int i = 0; i < LANES; i++)
        for (int j = 0; j < LANES; j++) rf[i][j] = 0;
      for (int b = 0; b < k; b++) begin
        logic [LANES*8-1:0] a, w;
        for (int l = 0; l < LANES; l++) begin
          a[l*8 +: 8] = 8'($urandom_range(255));
          w[l*8 +: 8] = 8'($urandom_range(255));
        end
        a_q.push_back(a);
        w_q.push_back(w);
        for (int i = 0; i < LANES; i++)
          for (int j = 0; j < LANES; j++) begin
            int unsigned ai, wj;
            ai = a[i*8 +: 8];
            wj = w[j*8 +: 8];
            rf[i][j] = rf[i][j] + ai * wj;
          end
      end
      e.idx  = t;
      e.k    = k;
      e.hash = 0;
      for (int i = 0; i < LANES; i++)
        for (int j = 0; j < LANES; j++)
          e.hash = e.hash + (i * LANES + j + 1) * rf[i][j];
      exp_q.push_back(e);
    end
  endtask

  task automatic launch(input int k, input int n);
    @(posedge clk); #1;
    start          = 1'b1;
    cfg_k_steps    = KW'(k);
    cfg_n_tiles    = TW'(n);
    done_cnt       = 0;
    job_beats      = 0;
    first_beat_cyc = -1;
    outv_cyc       = -1;
    done_cyc       = -1;
    start_cyc      = cyc;
    @(posedge clk); #1;
    start       = 1'b0;
    cfg_k_steps = KW'($urandom);
    cfg_n_tiles = TW'($urandom);
    check("busy_after_start", busy, 1);
  endtask

  task automatic flush();
    a_q.delete();
    w_q.delete();
    exp_q.delete();
    beats_in_tile = 0;
  endtask

  task automatic run_job(input int k, input int n, input int pv, input int bp,
                         input bit spurious, input bit time_chk);
    p_valid   = pv;
    bp_cycles = bp;
    gen_job(k, n);
    launch(k, n);
    if (spurious) begin
      repeat (2) @(posedge clk);
      #1;
      start       = 1'b1;
      cfg_k_steps = KW'(k + 5);
      cfg_n_tiles = TW'(n + 7);
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int c = 0; c < 5000 && done_cyc < 0; c++) @(posedge clk);
    check("done_seen", (done_cyc >= 0), 1);
    repeat (4) @(posedge clk);
    #1;
    check("one_done", done_cnt, 1);
    check("busy_low_after_done", busy, 0);
    check("job_beats", job_beats, k * n);
    check("tiles_left", exp_q.size(), 0);
    if (time_chk) begin
      check("first_beat_latency", first_beat_cyc - start_cyc, 1);
      check("out_valid_latency", outv_cyc - start_cyc, k + 1 + LAT);
      check("done_latency", done_cyc - start_cyc, k + 2 + LAT);
    end
    if (k == 0 || n == 0) begin
      check("empty_job_done_window", (done_cyc - start_cyc >= 1 && done_cyc - start_cyc <= 2), 1);
      check("empty_job_no_out_valid", outv_cyc, -1);
    end
    flush();
  endtask

  initial begin
    rst_in      = 1'b1;
    start       = 1'b0;
    cfg_k_steps = '0;
    cfg_n_tiles = '0;
    op_valid    = 1'b0;
    out_ready   = 1'b1;
    a_cur       = '0;
    w_cur       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_op_ready", op_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_tile_idx", out_tile_idx, 0);
    check("rst_pe_input_valid", pe_input_valid, 0);
    @(posedge clk); #1;
    rst_in  = 1'b0;
    mon_off = 1'b0;

    run_job(4, 1, 100, 0, 1'b0, 1'b1);   // single tile, timing
    run_job(3, 3, 100, 5, 1'b1, 1'b0);   // writeback backpressure, ignored start
    run_job(8, 2, 50, 0, 1'b0, 1'b0);    // fetch stalls
    run_job(0, 3, 100, 0, 1'b0, 1'b0);   // empty reduction
    run_job(5, 0, 100, 0, 1'b0, 1'b0);   // empty tile count
    run_job(1, 2, 100, 0, 1'b0, 1'b0);   // load-only beats

    // Reset in the middle of a tile, on the second beat.
    p_valid   = 100;
    bp_cycles = 0;
    gen_job(4, 1);
    launch(4, 1);
    for (int c = 0; c < 100 && job_beats < 1; c++) @(negedge clk);
    @(posedge clk); #1;
    rst_in  = 1'b1;
    mon_off = 1'b1;
    @(negedge clk);
    check("no_beat_during_reset", pe_input_valid, 0);
    @(posedge clk); #1;
    rst_in = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_op_ready", op_ready, 0);
    check("mid_rst_out_valid", out_valid, 0);
    flush();
    done_cnt = 0;
    mon_off  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_no_done", done_cnt, 0);
    run_job(2, 1, 100, 0, 1'b0, 1'b1);

    for (int r = 0; r < 6; r++) begin
      run_job($urandom_range(10, 1), $urandom_range(4, 1), $urandom_range(100, 30),
              $urandom_range(3, 0), 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
